// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter: single-port arbiter for the 80x34 character RAM.
// The renderer owns the RAM whenever vid_active is high; host writes are
// buffered in a small FIFO and host reads are held in a one-entry request
// register, both serviced only in cycles the renderer leaves idle.
// Optional feature macro: CHAR_ARB_HOST_READ_EN enables the host read path
// and its FSM. Without it the read ports are tied off and writes drain on
// every non-video cycle.
module char_ram_arbiter #(
    parameter int WFIFO_DEPTH = 4
) (
    input  logic        clk25mhz,
    input  logic        reset_n,
    input  logic        vid_active,
    input  logic [11:0] vid_char_address,
    output logic [7:0]  vid_char_data,
    input  logic        host_wr_valid,
    output logic        host_wr_ready,
    input  logic [11:0] host_wr_addr,
    input  logic [7:0]  host_wr_data,
    input  logic        host_rd_valid,
    output logic        host_rd_ready,
    input  logic [11:0] host_rd_addr,
    output logic        host_rd_resp_valid,
    output logic [7:0]  host_rd_data,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam int IDX_W = $clog2(WFIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Write FIFO: {addr, data} entries, pointers one bit wider than the index
    logic [19:0]      fifo_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fill;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [11:0]      head_addr;
    logic [7:0]       head_data;

    // Read request state shared with the slot mux
    logic             rd_pend;
    logic [11:0]      rd_addr;

    assign fill          = wr_ptr - rd_ptr;
    assign fifo_empty    = (fill == '0);
    assign fifo_full     = (fill == PTR_W'(WFIFO_DEPTH));
    assign host_wr_ready = !fifo_full;
    // A full FIFO refuses the push even when a pop happens in the same cycle
    assign push          = host_wr_valid && !fifo_full;
    assign {head_addr, head_data} = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign vid_char_data = ram_rdata;

    // FIFO pointers advance on accepted pushes and on write slots granted
    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage is pure data and needs no reset
    always_ff @(posedge clk25mhz) begin
        if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= {host_wr_addr, host_wr_data};
    end

`ifdef CHAR_ARB_HOST_READ_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   rd_accept;

    // Reads wait for an empty FIFO so they always see every earlier write
    assign host_rd_ready = (state == IDLE) && fifo_empty;
    assign rd_accept     = host_rd_valid && host_rd_ready;
    assign rd_pend       = (state == RD_PEND);

    // FSM state register
    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: a read waits in RD_PEND for a non-video cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_accept) state_next = RD_PEND;
            RD_PEND: if (!vid_active) state_next = RD_DATA;
            RD_DATA: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the read address when the request is accepted
    always_ff @(posedge clk25mhz) begin
        if (rd_accept) rd_addr <= host_rd_addr;
    end

    // Capture RAM data one cycle after the read slot and pulse the response
    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            host_rd_resp_valid <= 1'b0;
            host_rd_data       <= '0;
        end else begin
            host_rd_resp_valid <= (state == RD_DATA);
            if (state == RD_DATA) host_rd_data <= ram_rdata;
        end
    end
`else
    logic unused_rd;

    assign unused_rd          = &{1'b0, host_rd_valid, host_rd_addr};
    assign host_rd_ready      = 1'b0;
    assign host_rd_resp_valid = 1'b0;
    assign host_rd_data       = '0;
    assign rd_pend            = 1'b0;
    assign rd_addr            = '0;
`endif

    // RAM slot mux: video first, then a pending read, then the FIFO head
    always_comb begin
        ram_addr  = vid_char_address;
        ram_we    = 1'b0;
        ram_wdata = '0;
        pop       = 1'b0;
        if (vid_active) begin
            ram_addr = vid_char_address;
        end else if (rd_pend) begin
            ram_addr = rd_addr;
        end else if (!fifo_empty) begin
            ram_addr  = head_addr;
            ram_wdata = head_data;
            ram_we    = 1'b1;
            pop       = 1'b1;
        end
    end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed testbench for char_ram_arbiter with a behavioural 1-cycle RAM.
module tb_char_ram_arbiter;

    logic        clk25mhz = 1'b0;
    logic        reset_n;
    logic        vid_active;
    logic [11:0] vid_char_address;
    logic [7:0]  vid_char_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [11:0] host_wr_addr;
    logic [7:0]  host_wr_data;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic [11:0] host_rd_addr;
    logic        host_rd_resp_valid;
    logic [7:0]  host_rd_data;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CHAR_ARB_HOST_READ_EN
    localparam logic EXP_RD_READY = 1'b1;
`else
    localparam logic EXP_RD_READY = 1'b0;
`endif

    logic [7:0] ram_mem [4096];

    always #20 clk25mhz = ~clk25mhz;

    // Synchronous character RAM model with one cycle read latency
    always @(posedge clk25mhz) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    char_ram_arbiter #(.WFIFO_DEPTH(4)) dut (
        .clk25mhz(clk25mhz), .reset_n(reset_n),
        .vid_active(vid_active), .vid_char_address(vid_char_address), .vid_char_data(vid_char_data),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_addr(host_rd_addr),
        .host_rd_resp_valid(host_rd_resp_valid), .host_rd_data(host_rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic cyc;
        @(posedge clk25mhz);
        #1;
    endtask

    task automatic mid;
        @(negedge clk25mhz);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; vid_active = 1'b0; vid_char_address = '0;
        host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        host_rd_valid = 1'b0; host_rd_addr = '0;
        repeat (2) @(posedge clk25mhz);
        mid;
        n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", host_wr_ready); end
        n_checks++; if (host_rd_ready !== EXP_RD_READY) begin n_fail++; $display("FAIL rst_rd_ready: got %b want %b", host_rd_ready, EXP_RD_READY); end
        n_checks++; if (host_rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0", host_rd_resp_valid); end
        n_checks++; if (host_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_rd_data: got %h want 00", host_rd_data); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", ram_we); end
        cyc;
        reset_n = 1'b1;
        mid;
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rel_we: got %b want 0", ram_we); end
        cyc;
    endtask

    task automatic test_single_write;
        vid_active = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = 12'h010; host_wr_data = 8'h41;
        mid;
        n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready0: got %b want 1", host_wr_ready); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sw_we0: got %b want 0", ram_we); end
        cyc;
        host_wr_valid = 1'b0;
        mid;
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL sw_we1: got %b want 1", ram_we); end
        n_checks++; if (ram_addr !== 12'h010) begin n_fail++; $display("FAIL sw_addr: got %h want 010", ram_addr); end
        n_checks++; if (ram_wdata !== 8'h41) begin n_fail++; $display("FAIL sw_wdata: got %h want 41", ram_wdata); end
        n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready1: got %b want 1", host_wr_ready); end
        cyc;
        mid;
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sw_we2: got %b want 0", ram_we); end
        cyc;
    endtask

    task automatic test_full_drain;
        vid_active = 1'b1; vid_char_address = 12'h7FF;
        for (int i = 0; i < 4; i++) begin
            host_wr_valid = 1'b1; host_wr_addr = 12'(12'h100 + i); host_wr_data = 8'(8'hA0 + i);
            mid;
            n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL fd_ready_%0d: got %b want 1", i, host_wr_ready); end
            n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL fd_we_%0d: got %b want 0", i, ram_we); end
            n_checks++; if (ram_addr !== 12'h7FF) begin n_fail++; $display("FAIL fd_vaddr_%0d: got %h want 7ff", i, ram_addr); end
            cyc;
        end
        // fifth write is refused while full
        host_wr_addr = 12'h104; host_wr_data = 8'hA4;
        mid;
        n_checks++; if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL fd_full_ready: got %b want 0", host_wr_ready); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL fd_full_we: got %b want 0", ram_we); end
        cyc;
        // first pop from full: push still refused this cycle
        vid_active = 1'b0;
        mid;
        n_checks++; if (host_wr_ready !== 1'b0) begin n_fail++; $display("FAIL fd_pop0_ready: got %b want 0", host_wr_ready); end
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h100 || ram_wdata !== 8'hA0) begin n_fail++; $display("FAIL fd_pop0: got we=%b a=%h d=%h want 1/100/a0", ram_we, ram_addr, ram_wdata); end
        cyc;
        mid;
        n_checks++; if (host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL fd_pop1_ready: got %b want 1", host_wr_ready); end
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h101 || ram_wdata !== 8'hA1) begin n_fail++; $display("FAIL fd_pop1: got we=%b a=%h d=%h want 1/101/a1", ram_we, ram_addr, ram_wdata); end
        cyc;
        host_wr_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            mid;
            n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'(12'h100 + i) || ram_wdata !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL fd_pop%0d: got we=%b a=%h d=%h want 1/%h/%h", i, ram_we, ram_addr, ram_wdata, 12'(12'h100 + i), 8'(8'hA0 + i)); end
            cyc;
        end
        mid;
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL fd_empty_we: got %b want 0", ram_we); end
        cyc;
    endtask

    task automatic test_preempt;
        vid_active = 1'b1; vid_char_address = 12'h000;
        host_wr_valid = 1'b1; host_wr_addr = 12'h300; host_wr_data = 8'h11;
        cyc;
        host_wr_addr = 12'hB00; host_wr_data = 8'h22;
        cyc;
        host_wr_valid = 1'b0;
        vid_active = 1'b0;
        mid;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h300) begin n_fail++; $display("FAIL pe_pop0: got we=%b a=%h want 1/300", ram_we, ram_addr); end
        cyc;
        vid_active = 1'b1; vid_char_address = 12'h010;
        mid;
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 12'h010) begin n_fail++; $display("FAIL pe_hold: got we=%b a=%h want 0/010", ram_we, ram_addr); end
        cyc;
        vid_active = 1'b0;
        mid;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'hB00 || ram_wdata !== 8'h22) begin n_fail++; $display("FAIL pe_pop1: got we=%b a=%h d=%h want 1/b00/22", ram_we, ram_addr, ram_wdata); end
        n_checks++; if (vid_char_data !== 8'h41) begin n_fail++; $display("FAIL pe_vid_data: got %h want 41", vid_char_data); end
        cyc;
        vid_active = 1'b1; vid_char_address = 12'hFA0;
        mid;
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 12'hFA0) begin n_fail++; $display("FAIL pe_hiaddr: got we=%b a=%h want 0/fa0", ram_we, ram_addr); end
        cyc;
        vid_active = 1'b0;
    endtask

`ifdef CHAR_ARB_HOST_READ_EN
    task automatic test_read_preempt;
        vid_active = 1'b0;
        host_wr_valid = 1'b1; host_wr_addr = 12'h123; host_wr_data = 8'h9A;
        cyc;
        host_wr_valid = 1'b0;
        cyc;
        vid_active = 1'b1; vid_char_address = 12'h050;
        host_rd_valid = 1'b1; host_rd_addr = 12'h123;
        mid;
        n_checks++; if (host_rd_ready !== 1'b1) begin n_fail++; $display("FAIL rp_ready: got %b want 1", host_rd_ready); end
        cyc;
        host_rd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vid_char_address = 12'(12'h400 + i);
            mid;
            n_checks++; if (ram_addr !== 12'(12'h400 + i) || host_rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rp_vid_%0d: got a=%h resp=%b want %h/0", i, ram_addr, host_rd_resp_valid, 12'(12'h400 + i)); end
            cyc;
        end
        vid_active = 1'b0;
        mid;
        n_checks++; if (ram_addr !== 12'h123 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rp_issue: got a=%h we=%b want 123/0", ram_addr, ram_we); end
        cyc;
        mid;
        n_checks++; if (host_rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rp_early: got %b want 0", host_rd_resp_valid); end
        cyc;
        mid;
        n_checks++; if (host_rd_resp_valid !== 1'b1 || host_rd_data !== 8'h9A) begin n_fail++; $display("FAIL rp_resp: got v=%b d=%h want 1/9a", host_rd_resp_valid, host_rd_data); end
        n_checks++; if (host_rd_ready !== 1'b1) begin n_fail++; $display("FAIL rp_ready2: got %b want 1", host_rd_ready); end
        cyc;
        mid;
        n_checks++; if (host_rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rp_pulse: got %b want 0", host_rd_resp_valid); end
        cyc;
    endtask

    task automatic test_read_after_write;
        vid_active = 1'b1; vid_char_address = 12'h000;
        host_wr_valid = 1'b1; host_wr_addr = 12'h200; host_wr_data = 8'h55;
        cyc;
        host_wr_valid = 1'b0;
        host_rd_valid = 1'b1; host_rd_addr = 12'h200;
        for (int i = 0; i < 2; i++) begin
            mid;
            n_checks++; if (host_rd_ready !== 1'b0) begin n_fail++; $display("FAIL raw_block_%0d: got %b want 0", i, host_rd_ready); end
            cyc;
        end
        vid_active = 1'b0;
        mid;
        n_checks++; if (host_rd_ready !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 12'h200) begin n_fail++; $display("FAIL raw_pop: got rdy=%b we=%b a=%h want 0/1/200", host_rd_ready, ram_we, ram_addr); end
        cyc;
        mid;
        n_checks++; if (host_rd_ready !== 1'b1) begin n_fail++; $display("FAIL raw_ready: got %b want 1", host_rd_ready); end
        cyc;
        host_rd_valid = 1'b0;
        mid;
        n_checks++; if (ram_addr !== 12'h200 || ram_we !== 1'b0) begin n_fail++; $display("FAIL raw_issue: got a=%h we=%b want 200/0", ram_addr, ram_we); end
        cyc;
        cyc;
        mid;
        n_checks++; if (host_rd_resp_valid !== 1'b1 || host_rd_data !== 8'h55) begin n_fail++; $display("FAIL raw_resp: got v=%b d=%h want 1/55", host_rd_resp_valid, host_rd_data); end
        cyc;
        // read and write accepted together: the read sees the old value
        host_wr_valid = 1'b1; host_wr_addr = 12'h200; host_wr_data = 8'h66;
        host_rd_valid = 1'b1; host_rd_addr = 12'h200;
        mid;
        n_checks++; if (host_rd_ready !== 1'b1 || host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL ord_ready: got rd=%b wr=%b want 1/1", host_rd_ready, host_wr_ready); end
        cyc;
        host_wr_valid = 1'b0; host_rd_valid = 1'b0;
        mid;
        n_checks++; if (ram_addr !== 12'h200 || ram_we !== 1'b0) begin n_fail++; $display("FAIL ord_issue: got a=%h we=%b want 200/0", ram_addr, ram_we); end
        cyc;
        mid;
        n_checks++; if (ram_we !== 1'b1 || ram_wdata !== 8'h66) begin n_fail++; $display("FAIL ord_wr: got we=%b d=%h want 1/66", ram_we, ram_wdata); end
        cyc;
        mid;
        n_checks++; if (host_rd_resp_valid !== 1'b1 || host_rd_data !== 8'h55) begin n_fail++; $display("FAIL ord_resp: got v=%b d=%h want 1/55", host_rd_resp_valid, host_rd_data); end
        cyc;
    endtask
`else
    task automatic test_read_tieoff;
        vid_active = 1'b0;
        host_rd_valid = 1'b1; host_rd_addr = 12'h010;
        host_wr_valid = 1'b1; host_wr_addr = 12'h020; host_wr_data = 8'h77;
        mid;
        n_checks++; if (host_rd_ready !== 1'b0 || host_wr_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got rd=%b wr=%b want 0/1", host_rd_ready, host_wr_ready); end
        cyc;
        host_wr_valid = 1'b0;
        mid;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h020 || ram_wdata !== 8'h77) begin n_fail++; $display("FAIL to_drain: got we=%b a=%h d=%h want 1/020/77", ram_we, ram_addr, ram_wdata); end
        cyc;
        for (int i = 0; i < 3; i++) begin
            mid;
            n_checks++; if (host_rd_ready !== 1'b0 || host_rd_resp_valid !== 1'b0 || host_rd_data !== 8'h00 || ram_we !== 1'b0) begin n_fail++; $display("FAIL to_idle_%0d: got rdy=%b v=%b d=%h we=%b want 0/0/00/0", i, host_rd_ready, host_rd_resp_valid, host_rd_data, ram_we); end
            cyc;
        end
        host_rd_valid = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        vid_active = 1'b1; vid_char_address = 12'h777;
`ifdef CHAR_ARB_HOST_READ_EN
        host_rd_valid = 1'b1; host_rd_addr = 12'h123;
        mid;
        n_checks++; if (host_rd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_rd_ready: got %b want 1", host_rd_ready); end
        cyc;
        host_rd_valid = 1'b0;
`endif
        host_wr_valid = 1'b1; host_wr_addr = 12'h600; host_wr_data = 8'h01;
        cyc;
        host_wr_addr = 12'h601; host_wr_data = 8'h02;
        cyc;
        host_wr_valid = 1'b0;
        vid_active = 1'b0;
        #4;
`ifdef CHAR_ARB_HOST_READ_EN
        n_checks++; if (ram_addr !== 12'h123 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rm_pre: got a=%h we=%b want 123/0", ram_addr, ram_we); end
`else
        n_checks++; if (ram_addr !== 12'h600 || ram_we !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got a=%h we=%b want 600/1", ram_addr, ram_we); end
`endif
        reset_n = 1'b0;
        #1;
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 12'h777) begin n_fail++; $display("FAIL rm_async_ram: got we=%b a=%h want 0/777", ram_we, ram_addr); end
        n_checks++; if (host_wr_ready !== 1'b1 || host_rd_ready !== EXP_RD_READY) begin n_fail++; $display("FAIL rm_async_ready: got wr=%b rd=%b want 1/%b", host_wr_ready, host_rd_ready, EXP_RD_READY); end
        n_checks++; if (host_rd_resp_valid !== 1'b0 || host_rd_data !== 8'h00) begin n_fail++; $display("FAIL rm_async_rd: got v=%b d=%h want 0/00", host_rd_resp_valid, host_rd_data); end
        cyc;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid;
            n_checks++; if (ram_we !== 1'b0 || host_rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after_%0d: got we=%b v=%b want 0/0", i, ram_we, host_rd_resp_valid); end
            cyc;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_drain();
        test_preempt();
`ifdef CHAR_ARB_HOST_READ_EN
        test_read_preempt();
        test_read_after_write();
`else
        test_read_tieoff();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_ram_arbiter.md
# char_ram_arbiter

Single-port arbiter for the 80x34 character RAM that feeds the 25 MHz text renderer. The renderer's per-cycle `char_address` fetch always owns the RAM during active video. Host (CPU/UART bridge) writes are buffered in a small FIFO, and host reads are held in a one-entry request register; both are serviced only in cycles the renderer does not use. The block sits between the renderer, the host bus bridge and the 2720x8 synchronous character RAM (1-cycle read latency).

## Interface
Parameters:
- `WFIFO_DEPTH`, default 4: write FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk25mhz`  in  1  pixel clock; all logic rises on it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vid_active`  in  1  renderer owns the RAM this cycle.
- `vid_char_address`  in  12  renderer fetch address.
- `vid_char_data`  out  8  `ram_rdata` passthrough; valid one cycle after a video slot.
- `host_wr_valid`, `host_wr_ready`  in/out  1  write request handshake.
- `host_wr_addr`  in  12  write address.
- `host_wr_data`  in  8  write data.
- `host_rd_valid`, `host_rd_ready`  in/out  1  read request handshake.
- `host_rd_addr`  in  12  read address.
- `host_rd_resp_valid`  out  1  one-cycle pulse; `host_rd_data` is valid.
- `host_rd_data`  out  8  registered read data.
- `ram_addr`  out  12  RAM address (combinational mux).
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  8  RAM write data.
- `ram_rdata`  in  8  RAM read data; corresponds to the address presented one cycle earlier.

## Operation
- A handshake completes on a rising edge where `valid & ready` are both high.
- `host_wr_ready = !full`. A push is refused when full, even if a pop occurs in the same cycle.
- `host_rd_ready = (state==IDLE) & (fifo empty)`. This forces every read to observe all previously accepted writes.
- If a read and a write are accepted in the same cycle, the read is ordered first.
- FSM states:
  - IDLE: if a read is accepted, latch `host_rd_addr` and go to RD_PEND.
  - RD_PEND: when `!vid_active`, drive `ram_addr = rd_addr` and go to RD_DATA.
  - RD_DATA: register `ram_rdata` into `host_rd_data`, pulse `host_rd_resp_valid`, return to IDLE.
- RAM slot priority, evaluated each cycle:
  1. `vid_active`: `ram_addr = vid_char_address`, `ram_we = 0`.
  2. state RD_PEND: issue the read.
  3. state IDLE or RD_DATA with FIFO non-empty: pop the head. Drive `ram_addr`/`ram_wdata` from the head and set `ram_we = 1`.
  4. Otherwise: `ram_addr = vid_char_address`, `ram_we = 0`.
- Writes queued behind a pending read wait until the read has issued.
- Addresses are 12 bits and are not range-checked; addresses at or above 2720 pass through unchanged.
- FIFO pointers are log2(WFIFO_DEPTH)+1 bits wide and wrap naturally. The count is 0..WFIFO_DEPTH.

## Timing
- Reset values:
  - `host_wr_ready = 1`, `host_rd_ready = 1`.
  - `host_rd_resp_valid = 0`, `host_rd_data = 0`.
  - `ram_we = 0`, FIFO empty, state IDLE.
- Write latency: accepted at edge N → `ram_we` high during cycle N+1 at the earliest; it is delayed while `vid_active` is high or a read is pending.
- Drain rate: one write per non-video cycle. `host_wr_ready` rises in the cycle after a pop from a full FIFO.
- Read latency: accepted at edge N with `vid_active` low → `ram_addr = rd_addr` in cycle N+1 → `host_rd_resp_valid` high in cycle N+3. Every video cycle spent in RD_PEND adds one cycle.
- `vid_active` is sampled combinationally. Asserting it in any cycle preempts the host access scheduled for that cycle. Preemption loses no data: FIFO and FSM state are held.
- Reset asserted mid-operation clears the FIFO and discards any pending read. No response pulse is produced for a discarded read.

## Configuration
- `CHAR_ARB_HOST_READ_EN` defined: host read path and FSM are present as described above.
- Undefined: read ports remain on the interface but are tied off. `host_rd_ready = 0`, `host_rd_resp_valid = 0`, `host_rd_data = 0`. The FSM is removed, so writes drain whenever `!vid_active`.

## Test plan
- Reset release, `vid_active = 0`, write 0x010/0x41 at edge N → cycle N+1 shows `ram_we = 1`, `ram_addr = 0x010`, `ram_wdata = 0x41`; `host_wr_ready` stays 1.
- `vid_active` held 1, `WFIFO_DEPTH = 4`, 5 back-to-back writes → 4 accepted, `host_wr_ready = 0` after the 4th, `ram_we` never 1. Drop `vid_active` → 4 writes drain in order on consecutive cycles, and ready rises one cycle after the first pop.
- Read 0x123 accepted while `vid_active = 1` for 10 cycles → `ram_addr` follows `vid_char_address` for all 10. The cycle after `vid_active` falls, `ram_addr = 0x123`. The response pulses 2 cycles later with the RAM model's data.
- Write 0x200/0x55, then immediately request a read of 0x200 → `host_rd_ready = 0` until the FIFO empties; the read returns 0x55.
- Assert `reset_n = 0` while in RD_PEND with 2 writes queued → no `host_rd_resp_valid` pulse, no `ram_we`. All outputs return to reset values asynchronously.
- Build without `CHAR_ARB_HOST_READ_EN`, hold `host_rd_valid = 1` → `host_rd_ready` stays 0, writes still drain normally.
